// File: rtl/mbist_pkg.sv
// Shared types for the MBIST failure logger: log entry layout, controller states
// and the syndrome helper.
package mbist_pkg;

    localparam int ELEM_W = 3;
    localparam int LOG_AW = 8;
    localparam int LOG_WL = 4;

    typedef struct packed {
        logic [LOG_AW-1:0] addr;
        logic [LOG_WL-1:0] syndrome;
        logic [ELEM_W-1:0] elem;
    } mbist_fail_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } mbist_log_state_e;

    function automatic logic [LOG_WL-1:0] calc_syndrome(input logic [LOG_WL-1:0] expected,
                                                        input logic [LOG_WL-1:0] actual);
        return expected ^ actual;
    endfunction

endpackage

// File: rtl/mbist_log_fifo.sv
// Circular-buffer FIFO of failure entries with a registered head and a
// synchronous flush that overrides push and pop.
module mbist_log_fifo
    import mbist_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  mbist_fail_entry_t push_data_i,
    input  logic              pop_ready_i,
    output logic              full_o,
    output logic              head_valid_o,
    output mbist_fail_entry_t head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    mbist_fail_entry_t mem_q [DEPTH];
    mbist_fail_entry_t head_q, head_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              head_valid_q, head_valid_d;
    logic              full_s, pop_s, push_s;

    assign full_s       = (count_q == FULL_CNT);
    assign pop_s        = head_valid_q & pop_ready_i & ~flush_i;
    assign push_s       = push_i & ~flush_i & (~full_s | pop_s);
    assign full_o       = full_s;
    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;

    // Pointer/count update and next head selection, bypassing a push that lands in the head slot
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (flush_i) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
            head_d       = '0;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PW + 1)'(1);
                2'b01:   count_d = count_q - (PW + 1)'(1);
                default: count_d = count_q;
            endcase
            head_valid_d = (count_d != (PW + 1)'(0));
            if (push_s && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data_i;
            end else if (head_valid_d) begin
                head_d = mem_q[rd_ptr_d];
            end else begin
                head_d = head_q;
            end
        end
    end

    // Control and head registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mbist_fail_logger.sv
// Captures failing MBIST compares into a drainable log with a saturating count
// and sticky flags. MBIST_FAIL_LOG_DEDUP_EN suppresses repeat pushes of the same address.
module mbist_fail_logger
    import mbist_pkg::*;
#(
    parameter int wcount  = 256,
    parameter int wlength = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(wcount)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_start,
    input  logic               run_done,
    input  logic               cmp_valid,
    input  logic               cmp_fail,
    input  logic [AW-1:0]      cmp_addr,
    input  logic [wlength-1:0] cmp_expected,
    input  logic [wlength-1:0] cmp_actual,
    input  logic [ELEM_W-1:0]  cmp_elem,
    output logic               log_valid,
    input  logic               log_ready,
    output logic [AW-1:0]      log_addr,
    output logic [wlength-1:0] log_syndrome,
    output logic [ELEM_W-1:0]  log_elem,
    output logic [CNT_W-1:0]   fail_count,
    output logic               any_fail,
    output logic               log_overflow,
    output logic               armed
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mbist_log_state_e  state_q, state_d;
    logic [CNT_W-1:0]  fail_count_q, fail_count_d;
    logic              any_fail_q, any_fail_d;
    logic              overflow_q, overflow_d;
    logic              armed_s, fail_ev_s, dup_s, push_try_s, room_s, push_s, drop_s;
    logic              fifo_full_s;
    mbist_fail_entry_t entry_s, head_s;

    // Controller state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: run_start re-arms from anywhere, run_done only ends an armed run
    always_comb begin
        state_d = state_q;
        if (run_start) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ARMED:   state_d = run_done ? HOLD : ARMED;
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // State decode
    always_comb begin
        armed_s = 1'b0;
        case (state_q)
            ARMED:   armed_s = 1'b1;
            default: armed_s = 1'b0;
        endcase
    end

    assign fail_ev_s = armed_s & ~run_start & cmp_valid & cmp_fail;

`ifdef MBIST_FAIL_LOG_DEDUP_EN
    logic [AW-1:0] last_addr_q;
    logic          last_valid_q;

    // Address of the most recent pushed entry in this run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else if (run_start) begin
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else if (push_s) begin
            last_addr_q  <= cmp_addr;
            last_valid_q <= 1'b1;
        end
    end

    assign dup_s = last_valid_q & (last_addr_q == cmp_addr);
`else
    assign dup_s = 1'b0;
`endif

    assign push_try_s = fail_ev_s & ~dup_s;
    assign room_s     = ~fifo_full_s | (log_valid & log_ready);
    assign push_s     = push_try_s & room_s;
    assign drop_s     = push_try_s & ~room_s;

    assign entry_s.addr     = cmp_addr;
    assign entry_s.syndrome = calc_syndrome(cmp_expected, cmp_actual);
    assign entry_s.elem     = cmp_elem;

    mbist_log_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .flush_i     (run_start),
        .push_i      (push_s),
        .push_data_i (entry_s),
        .pop_ready_i (log_ready),
        .full_o      (fifo_full_s),
        .head_valid_o(log_valid),
        .head_o      (head_s)
    );

    // Counter and sticky flag next state; run_start clears before any capture
    always_comb begin
        fail_count_d = fail_count_q;
        any_fail_d   = any_fail_q;
        overflow_d   = overflow_q;
        if (run_start) begin
            fail_count_d = '0;
            any_fail_d   = 1'b0;
            overflow_d   = 1'b0;
        end else if (fail_ev_s) begin
            if (fail_count_q != CNT_MAX) begin
                fail_count_d = fail_count_q + CNT_W'(1);
            end else begin
                fail_count_d = fail_count_q;
            end
            any_fail_d = 1'b1;
            overflow_d = overflow_q | drop_s;
        end else begin
            fail_count_d = fail_count_q;
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_count_q <= '0;
            any_fail_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            fail_count_q <= fail_count_d;
            any_fail_q   <= any_fail_d;
            overflow_q   <= overflow_d;
        end
    end

    assign log_addr     = head_s.addr;
    assign log_syndrome = head_s.syndrome;
    assign log_elem     = head_s.elem;
    assign fail_count   = fail_count_q;
    assign any_fail     = any_fail_q;
    assign log_overflow = overflow_q;
    assign armed        = armed_s;

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Scoreboard bench for mbist_fail_logger: directed failures push expected entries,
// a forked monitor checks every popped entry and head stability under backpressure.
module tb_mbist_fail_logger;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_start, run_done, cmp_valid, cmp_fail, log_ready;
    logic [7:0] cmp_addr;
    logic [3:0] cmp_expected, cmp_actual;
    logic [2:0] cmp_elem;
    logic       log_valid, any_fail, log_overflow, armed;
    logic [7:0] log_addr;
    logic [3:0] log_syndrome;
    logic [2:0] log_elem;
    logic [15:0] fail_count;

    int n_checks = 0;
    int n_errs   = 0;
    logic [14:0] sb[$];

    mbist_fail_logger dut (
        .clk(clk), .rst(rst), .run_start(run_start), .run_done(run_done),
        .cmp_valid(cmp_valid), .cmp_fail(cmp_fail), .cmp_addr(cmp_addr),
        .cmp_expected(cmp_expected), .cmp_actual(cmp_actual), .cmp_elem(cmp_elem),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
        .log_syndrome(log_syndrome), .log_elem(log_elem), .fail_count(fail_count),
        .any_fail(any_fail), .log_overflow(log_overflow), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        run_start = 1'b1;
        sb.delete();
        cyc();
        run_start = 1'b0;
    endtask

    task automatic fail_ev(input logic [7:0] a, input logic [3:0] e, input logic [3:0] act,
                           input logic [2:0] el, input bit exp_push);
        cmp_valid = 1'b1; cmp_fail = 1'b1;
        cmp_addr = a; cmp_expected = e; cmp_actual = act; cmp_elem = el;
        if (exp_push) sb.push_back({a, e ^ act, el});
        cyc();
        cmp_valid = 1'b0; cmp_fail = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        log_ready = 1'b1;
        while (sb.size() > 0 && budget < 40) begin
            cyc();
            budget++;
        end
        check("drain_done", sb.size(), 0);
        log_ready = 1'b0;
        check("empty_after_drain", log_valid, 0);
    endtask

    task automatic monitor();
        logic        stall;
        logic [14:0] held, cur, exp;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            cur = {log_addr, log_syndrome, log_elem};
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) check("head_stable", {log_valid, cur}, {1'b1, held});
                if (run_start) begin
                    stall = 1'b0;
                end else if (log_valid && log_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_entry: got 0x%0h expected none", cur);
                    end else begin
                        exp = sb.pop_front();
                        check("log_entry", cur, exp);
                    end
                    stall = 1'b0;
                end else if (log_valid) begin
                    stall = 1'b1;
                    held  = cur;
                end else begin
                    stall = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; run_start = 1'b0; run_done = 1'b0; cmp_valid = 1'b0; cmp_fail = 1'b0;
        log_ready = 1'b0; cmp_addr = '0; cmp_expected = '0; cmp_actual = '0; cmp_elem = '0;
        fork
            monitor();
        join_none
        repeat (2) cyc();
        check("rst_log_valid", log_valid, 0);
        check("rst_log_addr", log_addr, 0);
        check("rst_log_syndrome", log_syndrome, 0);
        check("rst_log_elem", log_elem, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_any_fail", any_fail, 0);
        check("rst_overflow", log_overflow, 0);
        check("rst_armed", armed, 0);
        rst = 1'b1;
        cyc();

        // failure in IDLE is ignored
        fail_ev(8'h11, 4'hF, 4'h0, 3'd1, 1'b0);
        check("idle_fail_count", fail_count, 0);
        check("idle_log_valid", log_valid, 0);

        // basic capture
        start_run();
        check("armed_after_start", armed, 1);
        cmp_valid = 1'b1; cmp_fail = 1'b0; cmp_addr = 8'h01;
        cyc();
        cmp_valid = 1'b0;
        check("pass_cmp_count", fail_count, 0);
        fail_ev(8'h3C, 4'hA, 4'h8, 3'd2, 1'b1);
        check("basic_log_valid", log_valid, 1);
        check("basic_log_addr", log_addr, 8'h3C);
        check("basic_log_syndrome", log_syndrome, 4'h2);
        check("basic_log_elem", log_elem, 3'd2);
        check("basic_fail_count", fail_count, 1);
        check("basic_any_fail", any_fail, 1);
        fail_ev(8'h3D, 4'h5, 4'h5, 3'd3, 1'b1);
        check("zero_syndrome_count", fail_count, 2);
        drain();

        // overflow with consumer stalled
        start_run();
        for (int i = 0; i < 10; i++) begin
            fail_ev(8'(i), 4'(i), 4'h0, 3'(i), i < 8);
        end
        check("ovf_fail_count", fail_count, 10);
        check("ovf_flag", log_overflow, 1);
        drain();

        // full FIFO with a pop in the same cycle as a push
        start_run();
        for (int i = 0; i < 8; i++) begin
            fail_ev(8'(8'h10 + i), 4'h1, 4'h0, 3'd4, 1'b1);
        end
        check("full_no_ovf", log_overflow, 0);
        log_ready = 1'b1;
        fail_ev(8'h55, 4'h3, 4'h0, 3'd5, 1'b1);
        log_ready = 1'b0;
        check("push_pop_no_ovf", log_overflow, 0);
        check("push_pop_count", fail_count, 9);
        fail_ev(8'h66, 4'h3, 4'h0, 3'd5, 1'b0);
        check("still_full_ovf", log_overflow, 1);
        drain();

        // gating by run_done and HOLD
        start_run();
        fail_ev(8'h20, 4'h8, 4'h1, 3'd0, 1'b1);
        run_done = 1'b1;
        fail_ev(8'h21, 4'h4, 4'h1, 3'd1, 1'b1);
        run_done = 1'b0;
        check("hold_armed", armed, 0);
        fail_ev(8'h22, 4'h2, 4'h1, 3'd2, 1'b0);
        check("hold_fail_count", fail_count, 2);
        drain();

        // flush priority over capture and pop
        start_run();
        fail_ev(8'h30, 4'h1, 4'h0, 3'd0, 1'b0);
        run_start = 1'b1;
        log_ready = 1'b1;
        sb.delete();
        fail_ev(8'h31, 4'h1, 4'h0, 3'd0, 1'b0);
        run_start = 1'b0;
        log_ready = 1'b0;
        check("flush_log_valid", log_valid, 0);
        check("flush_fail_count", fail_count, 0);
        check("flush_any_fail", any_fail, 0);
        check("flush_armed", armed, 1);

        // repeated address
        start_run();
`ifdef MBIST_FAIL_LOG_DEDUP_EN
        fail_ev(8'h07, 4'h1, 4'h0, 3'd1, 1'b1);
        fail_ev(8'h07, 4'h2, 4'h0, 3'd1, 1'b0);
        fail_ev(8'h07, 4'h4, 4'h0, 3'd1, 1'b0);
        fail_ev(8'h09, 4'h8, 4'h0, 3'd1, 1'b1);
`else
        fail_ev(8'h07, 4'h1, 4'h0, 3'd1, 1'b1);
        fail_ev(8'h07, 4'h2, 4'h0, 3'd1, 1'b1);
        fail_ev(8'h07, 4'h4, 4'h0, 3'd1, 1'b1);
        fail_ev(8'h09, 4'h8, 4'h0, 3'd1, 1'b1);
`endif
        check("dedup_fail_count", fail_count, 4);
        check("dedup_no_ovf", log_overflow, 0);
        drain();

        // asynchronous reset mid-run
        start_run();
        fail_ev(8'h40, 4'hC, 4'h0, 3'd6, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_log_valid", log_valid, 0);
        check("arst_fail_count", fail_count, 0);
        check("arst_any_fail", any_fail, 0);
        check("arst_armed", armed, 0);
        cyc();
        rst = 1'b1;
        cyc();
        check("post_rst_log_valid", log_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
